// File: rtl/muldiv_unit_pkg.sv
// Shared codes: opcode/funct types, muldiv op encodings, FSM states.
// funct_to_mdop maps a SPECIAL funct field onto the muldiv op bus.
package muldiv_unit_pkg;

  typedef enum logic [5:0] {
    OPC_SPECIAL = 6'h00
  } opcode_t;

  typedef enum logic [5:0] {
    FUNC_MFHI  = 6'h10,
    FUNC_MTHI  = 6'h11,
    FUNC_MFLO  = 6'h12,
    FUNC_MTLO  = 6'h13,
    FUNC_MULT  = 6'h18,
    FUNC_MULTU = 6'h19,
    FUNC_DIV   = 6'h1a,
    FUNC_DIVU  = 6'h1b
  } funct_t;

  typedef enum logic [2:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MTHI,
    MD_MTLO
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    DIV_RUN,
    DIV_FIX
  } md_state_t;

  function automatic logic is_muldiv(funct_t f);
    case (f)
      FUNC_MULT, FUNC_MULTU,
      FUNC_DIV,  FUNC_DIVU,
      FUNC_MTHI, FUNC_MTLO: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic muldiv_op_t funct_to_mdop(funct_t f);
    case (f)
      FUNC_MULTU: return MD_MULTU;
      FUNC_DIV:   return MD_DIV;
      FUNC_DIVU:  return MD_DIVU;
      FUNC_MTHI:  return MD_MTHI;
      FUNC_MTLO:  return MD_MTLO;
      default:    return MD_MULT;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: restoring radix-2 magnitude divider, one quotient bit/cycle.
// Ports: load_i latches operands, step_i runs one bit, last_o on final step.
module div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Dividend bits leave quot's MSB into rem while quotient bits enter
  // at the LSB; a zero divisor yields all-ones quotient, rem = dividend.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
      cnt_d  = CW'(WIDTH);
    end else if (step_i) begin
      if (!diff[WIDTH]) begin
        rem_d  = diff[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = shifted[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: 1-cycle MULT/MT*, iterative DIV via div_iter.
// Ports: start_i/op_i/rs_i/rt_i request, flush_i abort; hi_o/lo_o/busy_o/done_o.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  muldiv_op_t       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  md_state_t        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             div0_q, div0_d;

  logic             is_signed;
  logic             div_load;
  logic             div_step;
  logic             div_last;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH-1:0] mag_rs, mag_rt;
  logic [WIDTH-1:0] quot, rem;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);

  // Extending to 2W and keeping the low 2W bits gives the signed
  // product for sign-extended operands and the unsigned one otherwise.
  assign mul_a = {{WIDTH{is_signed & rs_i[WIDTH-1]}}, rs_i};
  assign mul_b = {{WIDTH{is_signed & rt_i[WIDTH-1]}}, rt_i};
  assign prod  = mul_a * mul_b;

  assign mag_rs = (is_signed && rs_i[WIDTH-1]) ? -rs_i : rs_i;
  assign mag_rt = (is_signed && rt_i[WIDTH-1]) ? -rt_i : rt_i;

  assign div_step = (state_q == DIV_RUN);

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (mag_rs),
    .divisor_i  (mag_rt),
    .quot_o     (quot),
    .rem_o      (rem),
    .last_o     (div_last)
  );

  // Divide by zero: remainder magnitude is |rs|, so the sign fix
  // restores rs; only the quotient needs forcing to all ones.
  assign q_fix = div0_q ? '1 : (negq_q ? -quot : quot);
  assign r_fix = negr_q ? -rem : rem;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    negq_d   = negq_q;
    negr_d   = negr_q;
    div0_d   = div0_q;
    div_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          case (op_i)
            MD_MULT, MD_MULTU: {hi_d, lo_d} = prod;
            MD_MTHI:           hi_d = rs_i;
            MD_MTLO:           lo_d = rs_i;
            MD_DIV, MD_DIVU: begin
              div_load = 1'b1;
              negq_d   = is_signed
                       & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
              negr_d   = is_signed & rs_i[WIDTH-1];
              div0_d   = (rt_i == '0);
              state_d  = DIV_RUN;
            end
            default: ;
          endcase
        end
      end
      DIV_RUN: begin
        if (flush_i)       state_d = IDLE;
        else if (div_last) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        state_d = IDLE;
        if (!flush_i) begin
          hi_d   = r_fix;
          lo_d   = q_fix;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result scoreboard.
// Inputs change 1ns after rising edges; outputs sampled there too.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  muldiv_op_t   op_i;
  logic [W-1:0] rs_i;
  logic [W-1:0] rt_i;
  logic         flush_i;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         busy_o;
  logic         done_o;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  res_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .op_i    (op_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .flush_i (flush_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] b2w(logic b);
    return {{(W-1){1'b0}}, b};
  endfunction

  task automatic chk(string tag, logic [W-1:0] got,
                     logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic res_t div_model(logic sgn, logic [W-1:0] a,
                                     logic [W-1:0] b);
    logic signed [W-1:0] da, db;
    res_t r;
    da = a;
    db = b;
    if (b == '0) begin
      r.hi = a;
      r.lo = '1;
    end else if (sgn && a == MIN && b == '1) begin
      r.hi = '0;
      r.lo = MIN;
    end else if (sgn) begin
      r.lo = da / db;
      r.hi = da % db;
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(muldiv_op_t op, logic [W-1:0] a,
                       logic [W-1:0] b);
    start_i = 1'b1;
    op_i    = op;
    rs_i    = a;
    rt_i    = b;
    step();
    start_i = 1'b0;
  endtask

  task automatic check_mul(string tag);
    res_t e;
    e = sbq.pop_front();
    chk({tag, " hi"}, hi_o, e.hi);
    chk({tag, " lo"}, lo_o, e.lo);
    chk({tag, " busy"}, b2w(busy_o), '0);
    chk({tag, " done"}, b2w(done_o), '0);
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  task automatic finish_div(string tag);
    int   nb = 0;
    logic seen = 1'b0;
    logic held = 1'b1;
    res_t e;
    for (int i = 0; i < 100; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) nb++;
      if (hi_o !== model_hi || lo_o !== model_lo) held = 1'b0;
      step();
    end
    chk({tag, " done seen"}, b2w(seen), 32'd1);
    chk({tag, " busy cycles"}, W'(nb), W'(W + 1));
    chk({tag, " hilo held"}, b2w(held), 32'd1);
    chk({tag, " busy at done"}, b2w(busy_o), '0);
    e = sbq.pop_front();
    chk({tag, " hi"}, hi_o, e.hi);
    chk({tag, " lo"}, lo_o, e.lo);
    model_hi = e.hi;
    model_lo = e.lo;
    step();
    chk({tag, " done pulse"}, b2w(done_o), '0);
  endtask

  task automatic watch_quiet(string tag);
    int nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) nd++;
      step();
    end
    chk({tag, " no done"}, W'(nd), '0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    res_t r;
    reset   = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = MD_MULT;
    rs_i    = '0;
    rt_i    = '0;
    #2;
    chk("rst hi", hi_o, '0);
    chk("rst lo", lo_o, '0);
    chk("rst busy", b2w(busy_o), '0);
    chk("rst done", b2w(done_o), '0);
    @(posedge clk);
    step();
    reset = 1'b0;

    sbq.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check_mul("mult");

    sbq.push_back({32'd2, 32'd14});
    do_op(MD_DIVU, 32'd100, 32'd7);
    finish_div("divu");

    sbq.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    finish_div("div neg");

    sbq.push_back({32'h0, MIN});
    do_op(MD_DIV, MIN, 32'hFFFF_FFFF);
    finish_div("div ovf");

    sbq.push_back({32'h0000_1234, 32'hFFFF_FFFF});
    do_op(MD_DIVU, 32'h0000_1234, 32'd0);
    finish_div("divu by0");

    sbq.push_back({32'hFFFF_FFFB, 32'hFFFF_FFFF});
    do_op(MD_DIV, 32'hFFFF_FFFB, 32'd0);
    finish_div("div by0");

    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(4, 28);
      if (b == '0) b = 32'd5;
      r = div_model(i[0], a, b);
      sbq.push_back(r);
      do_op(i[0] ? MD_DIV : MD_DIVU, a, b);
      finish_div($sformatf("rnd%0d", i));
    end

    do_op(MD_MTHI, 32'h0000_AAAA, 32'h0);
    chk("mthi hi", hi_o, 32'h0000_AAAA);
    chk("mthi lo", lo_o, model_lo);
    model_hi = 32'h0000_AAAA;
    do_op(MD_MTLO, 32'h0000_5555, 32'h0);
    chk("mtlo lo", lo_o, 32'h0000_5555);
    chk("mtlo hi", hi_o, 32'h0000_AAAA);
    model_lo = 32'h0000_5555;

    do_op(MD_DIV, 32'd100, 32'd7);
    step();
    step();
    do_op(MD_MTHI, 32'h0000_1111, 32'h0);
    chk("ignored start busy", b2w(busy_o), 32'd1);
    repeat (6) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush busy", b2w(busy_o), '0);
    chk("flush hi", hi_o, 32'h0000_AAAA);
    chk("flush lo", lo_o, 32'h0000_5555);
    watch_quiet("flush");
    chk("flush hi later", hi_o, 32'h0000_AAAA);

    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = MD_MTHI;
    rs_i    = 32'h0000_2222;
    step();
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("idle flush hi", hi_o, 32'h0000_AAAA);
    chk("idle flush busy", b2w(busy_o), '0);

    do_op(MD_DIV, 32'd1000, 32'd3);
    repeat (4) step();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst hi", hi_o, '0);
    chk("midrst lo", lo_o, '0);
    chk("midrst busy", b2w(busy_o), '0);
    chk("midrst done", b2w(done_o), '0);
    model_hi = '0;
    model_lo = '0;
    step();
    reset = 1'b0;
    watch_quiet("midrst");
    chk("midrst busy later", b2w(busy_o), '0);

    sbq.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_mul("multu");

    chk("sb empty", W'(sbq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
